// File: rtl/cache_line_wb.sv
// ---------------------------------------------------------------------------
// cache_line_wb
//
// One write-back cache line for the hybrid cache: a tag, 2^WORDSBITS data
// words, NRD read ports, one byte-enabled write port and a memory master port
// used for writeback (FLUSH) and refill (FILL). The controller issues
// ctl_fill/ctl_flush pulses and ages lines using line_ttl_o.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   rd_addr_i/rd_req_i    NRD packed read addresses / requests
//   rd_data_o/rd_valid_o  registered read data, valid the cycle after a hit
//   rd_miss_o             rd_req & !hit (combinational)
//   wr_addr_i/wr_data_i/wr_be_i/wr_req_i  byte-enabled write
//   wr_ack_o              write hit committed at this edge (combinational)
//   ctl_flush_i/ctl_fill_i/ctl_region_i   commands (sampled in CACHE only)
//   line_ready_o/line_valid_o/line_dirty_o/line_region_o/line_ttl_o  status
//   ttl_tick_i            aging strobe
//   mem_*                 memory master port
//   dbg_state_o           current FSM state
//
// Memory handshake: a request (mem_wrreq_o or mem_rdreq_o) is held with
// mem_addr_o/mem_wdata_o stable until the cycle where mem_pause_i is low;
// that edge is the acceptance. Read returns come back in request order, one
// word per mem_rvalid_i, with any latency.
// ---------------------------------------------------------------------------
module cache_line_wb #(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int WORDSBITS = 5,
  parameter int NRD       = 2,
  parameter int TTLBITS   = 8
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic [NRD*ADDRBITS-1:0]                           rd_addr_i,
  input  logic [NRD-1:0]                                    rd_req_i,
  output logic [NRD*DATABITS-1:0]                           rd_data_o,
  output logic [NRD-1:0]                                    rd_valid_o,
  output logic [NRD-1:0]                                    rd_miss_o,
  input  logic [ADDRBITS-1:0]                               wr_addr_i,
  input  logic [DATABITS-1:0]                               wr_data_i,
  input  logic [DATABITS/8-1:0]                             wr_be_i,
  input  logic                                              wr_req_i,
  output logic                                              wr_ack_o,
  input  logic                                              ctl_flush_i,
  input  logic                                              ctl_fill_i,
  input  logic [ADDRBITS-WORDSBITS-$clog2(DATABITS/8)-1:0]  ctl_region_i,
  output logic                                              line_ready_o,
  output logic                                              line_valid_o,
  output logic                                              line_dirty_o,
  output logic [ADDRBITS-WORDSBITS-$clog2(DATABITS/8)-1:0]  line_region_o,
  output logic [TTLBITS-1:0]                                line_ttl_o,
  input  logic                                              ttl_tick_i,
  output logic [ADDRBITS-1:0]                               mem_addr_o,
  output logic [DATABITS-1:0]                               mem_wdata_o,
  output logic                                              mem_wrreq_o,
  output logic                                              mem_rdreq_o,
  input  logic                                              mem_pause_i,
  input  logic [DATABITS-1:0]                               mem_rdata_i,
  input  logic                                              mem_rvalid_i,
  output logic [1:0]                                        dbg_state_o
);

  localparam int BYTES   = DATABITS / 8;
  localparam int BOFF    = $clog2(BYTES);
  localparam int LSB     = WORDSBITS + BOFF;
  localparam int TAGBITS = ADDRBITS - LSB;
  localparam int NWORDS  = 1 << WORDSBITS;

  localparam logic [WORDSBITS-1:0] LAST_IDX = '1;
  localparam logic [TTLBITS-1:0]   MAXTTL   = '1;

  typedef enum logic [1:0] {
    S_CACHE = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                             state_q;
  logic                               line_valid_q;
  logic                               line_dirty_q;
  logic [TAGBITS-1:0]                 line_region_q;
  logic [TTLBITS-1:0]                 line_ttl_q;
  logic                               fill_after_q;   // flush is followed by a fill
  logic [TAGBITS-1:0]                 pend_region_q;  // tag to fill after the flush
  logic [WORDSBITS-1:0]               wb_idx_q;       // flush word index
  logic [WORDSBITS-1:0]               rq_idx_q;       // fill request index
  logic [WORDSBITS-1:0]               rt_idx_q;       // fill return index
  logic                               mem_wrreq_q;
  logic                               mem_rdreq_q;
  logic [ADDRBITS-1:0]                mem_addr_q;
  logic [DATABITS-1:0]                mem_wdata_q;
  logic [NRD-1:0][DATABITS-1:0]       rd_data_q;
  logic [NRD-1:0]                     rd_valid_q;

  logic [DATABITS-1:0]                mem_q [NWORDS];

  // -------------------------------------------------------------------------
  // Hit detection and write merge
  // -------------------------------------------------------------------------
  logic                               in_cache;
  logic [NRD-1:0]                     rd_hit;
  logic [WORDSBITS-1:0]               rd_idx [NRD];
  logic [WORDSBITS-1:0]               wr_idx;
  logic                               wr_hit;
  logic                               wr_dirty;
  logic                               dirty_eff;
  logic [DATABITS-1:0]                wr_merged;
  logic [DATABITS-1:0]                flush_w0;
  logic                               any_hit;
  logic [WORDSBITS-1:0]               wb_idx_nx;
  logic [WORDSBITS-1:0]               rq_idx_nx;
  logic [WORDSBITS-1:0]               rt_idx_nx;
  logic [TTLBITS-1:0]                 ttl_d;
  logic                               unused_addr_bits;

  assign in_cache = (state_q == S_CACHE);

  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_idx[i] = rd_addr_i[i*ADDRBITS+BOFF +: WORDSBITS];
      rd_hit[i] = in_cache & line_valid_q & rd_req_i[i] &
                  (rd_addr_i[i*ADDRBITS+LSB +: TAGBITS] == line_region_q);
    end
  end

  assign wr_idx = wr_addr_i[BOFF +: WORDSBITS];
  assign wr_hit = in_cache & line_valid_q & wr_req_i &
                  (wr_addr_i[LSB +: TAGBITS] == line_region_q);
  // An all-zero byte enable is still acknowledged but changes nothing.
  assign wr_dirty  = wr_hit & (|wr_be_i);
  // A write committed in the command cycle counts toward the flush decision.
  assign dirty_eff = line_dirty_q | wr_dirty;
  assign any_hit   = (|rd_hit) | wr_hit;

  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int b = 0; b < BYTES; b++) begin
      if (wr_be_i[b]) wr_merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end

  // The first flush word is launched at the command edge, so it must see a
  // write landing on word 0 at that same edge.
  assign flush_w0 = (wr_hit && wr_idx == '0) ? wr_merged : mem_q[0];

  assign wb_idx_nx = wb_idx_q + WORDSBITS'(1);
  assign rq_idx_nx = rq_idx_q + WORDSBITS'(1);
  assign rt_idx_nx = rt_idx_q + WORDSBITS'(1);

  always_comb begin
    ttl_d = line_ttl_q;
    if (any_hit) begin
      ttl_d = MAXTTL;
    end else if (ttl_tick_i && line_ttl_q != '0) begin
      ttl_d = line_ttl_q - TTLBITS'(1);
    end
  end

  // Byte-offset address bits never select anything inside a word.
  assign unused_addr_bits = ^{rd_addr_i, wr_addr_i};

  function automatic logic [ADDRBITS-1:0] word_addr(input logic [TAGBITS-1:0]   tag,
                                                     input logic [WORDSBITS-1:0] idx);
    logic [ADDRBITS-1:0] a;
    a = '0;
    a[ADDRBITS-1:LSB] = tag;
    a[LSB-1:BOFF]     = idx;
    return a;
  endfunction

  // -------------------------------------------------------------------------
  // Data array: written only by write hits (CACHE) or fill returns (FILL),
  // which are mutually exclusive. Not reset: contents are meaningless until
  // a fill completes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem_q[wr_idx] <= wr_merged;
    end else if (state_q == S_FILL && mem_rvalid_i) begin
      mem_q[rt_idx_q] <= mem_rdata_i;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: registered, read-before-write against the array
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      for (int i = 0; i < NRD; i++) begin
        if (rd_hit[i]) rd_data_q[i] <= mem_q[rd_idx[i]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Line FSM with registered memory-port outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_CACHE;
      line_valid_q  <= 1'b0;
      line_dirty_q  <= 1'b0;
      line_region_q <= '0;
      line_ttl_q    <= MAXTTL;
      fill_after_q  <= 1'b0;
      pend_region_q <= '0;
      wb_idx_q      <= '0;
      rq_idx_q      <= '0;
      rt_idx_q      <= '0;
      mem_wrreq_q   <= 1'b0;
      mem_rdreq_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        S_CACHE: begin
          line_ttl_q <= ttl_d;
          if (wr_dirty) line_dirty_q <= 1'b1;

          if (ctl_fill_i && ctl_flush_i && line_valid_q && dirty_eff) begin
            // Write back first, then refill with the latched tag.
            pend_region_q <= ctl_region_i;
            fill_after_q  <= 1'b1;
            state_q       <= S_FLUSH;
            wb_idx_q      <= '0;
            mem_wrreq_q   <= 1'b1;
            mem_addr_q    <= word_addr(line_region_q, '0);
            mem_wdata_q   <= flush_w0;
          end else if (ctl_fill_i) begin
            // Contents discarded without writeback.
            pend_region_q <= ctl_region_i;
            state_q       <= S_FILL;
            line_region_q <= ctl_region_i;
            line_valid_q  <= 1'b0;
            rq_idx_q      <= '0;
            rt_idx_q      <= '0;
            mem_rdreq_q   <= 1'b1;
            mem_addr_q    <= word_addr(ctl_region_i, '0);
          end else if (ctl_flush_i) begin
            if (line_valid_q && dirty_eff) begin
              fill_after_q <= 1'b0;
              state_q      <= S_FLUSH;
              wb_idx_q     <= '0;
              mem_wrreq_q  <= 1'b1;
              mem_addr_q   <= word_addr(line_region_q, '0);
              mem_wdata_q  <= flush_w0;
            end else begin
              // Nothing to write back: just drop the line.
              line_valid_q <= 1'b0;
            end
          end
        end

        S_FLUSH: begin
          if (!mem_pause_i) begin
            if (wb_idx_q == LAST_IDX) begin
              mem_wrreq_q  <= 1'b0;
              line_dirty_q <= 1'b0;
              if (fill_after_q) begin
                state_q       <= S_FILL;
                line_region_q <= pend_region_q;
                line_valid_q  <= 1'b0;
                rq_idx_q      <= '0;
                rt_idx_q      <= '0;
                mem_rdreq_q   <= 1'b1;
                mem_addr_q    <= word_addr(pend_region_q, '0);
              end else begin
                state_q      <= S_CACHE;
                line_valid_q <= 1'b0;
              end
            end else begin
              // The array is frozen during FLUSH, so the next word can be
              // fetched straight from it.
              wb_idx_q    <= wb_idx_nx;
              mem_addr_q  <= word_addr(line_region_q, wb_idx_nx);
              mem_wdata_q <= mem_q[wb_idx_nx];
            end
          end
        end

        S_FILL: begin
          if (mem_rdreq_q && !mem_pause_i) begin
            if (rq_idx_q == LAST_IDX) begin
              mem_rdreq_q <= 1'b0;
            end else begin
              rq_idx_q   <= rq_idx_nx;
              mem_addr_q <= word_addr(line_region_q, rq_idx_nx);
            end
          end
          if (mem_rvalid_i) begin
            if (rt_idx_q == LAST_IDX) begin
              state_q      <= S_CACHE;
              line_valid_q <= 1'b1;
              line_dirty_q <= 1'b0;
              line_ttl_q   <= MAXTTL;
              mem_rdreq_q  <= 1'b0;
            end else begin
              rt_idx_q <= rt_idx_nx;
            end
          end
        end

        default: begin
          state_q     <= S_CACHE;
          mem_wrreq_q <= 1'b0;
          mem_rdreq_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_miss_o     = rd_req_i & ~rd_hit;
  assign wr_ack_o      = wr_hit;
  assign line_ready_o  = in_cache;
  assign line_valid_o  = line_valid_q;
  assign line_dirty_o  = line_dirty_q;
  assign line_region_o = line_region_q;
  assign line_ttl_o    = line_ttl_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_wrreq_o   = mem_wrreq_q;
  assign mem_rdreq_o   = mem_rdreq_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cache_line_wb.sv
// ---------------------------------------------------------------------------
// tb_cache_line_wb
//
// Directed bench for cache_line_wb with default parameters (32-bit address
// and data, 32 words per line, 2 read ports, 8-bit TTL). Stimulus pushes the
// expected memory writes, memory read addresses and read-port data into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// A zero-latency memory model answers each accepted read with
// fill_base + 3*word_index.
// ---------------------------------------------------------------------------
module tb_cache_line_wb;

  localparam int AB = 32;
  localparam int DB = 32;
  localparam int WB = 5;
  localparam int NR = 2;
  localparam int TB = 8;
  localparam int NW = 32;
  localparam int TG = AB - WB - 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [NR*AB-1:0] rd_addr;
  logic [NR-1:0]    rd_req;
  logic [NR*DB-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic [NR-1:0]    rd_miss;
  logic [AB-1:0]    wr_addr;
  logic [DB-1:0]    wr_data;
  logic [3:0]       wr_be;
  logic             wr_req;
  logic             wr_ack;
  logic             ctl_flush;
  logic             ctl_fill;
  logic [TG-1:0]    ctl_region;
  logic             line_ready;
  logic             line_valid;
  logic             line_dirty;
  logic [TG-1:0]    line_region;
  logic [TB-1:0]    line_ttl;
  logic             ttl_tick;
  logic [AB-1:0]    mem_addr;
  logic [DB-1:0]    mem_wdata;
  logic             mem_wrreq;
  logic             mem_rdreq;
  logic             mem_pause = 1'b0;
  logic [DB-1:0]    mem_rdata;
  logic             mem_rvalid;
  logic [1:0]       dbg_state;

  cache_line_wb dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_addr_i    (rd_addr),
    .rd_req_i     (rd_req),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .rd_miss_o    (rd_miss),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_be_i      (wr_be),
    .wr_req_i     (wr_req),
    .wr_ack_o     (wr_ack),
    .ctl_flush_i  (ctl_flush),
    .ctl_fill_i   (ctl_fill),
    .ctl_region_i (ctl_region),
    .line_ready_o (line_ready),
    .line_valid_o (line_valid),
    .line_dirty_o (line_dirty),
    .line_region_o(line_region),
    .line_ttl_o   (line_ttl),
    .ttl_tick_i   (ttl_tick),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wrreq_o  (mem_wrreq),
    .mem_rdreq_o  (mem_rdreq),
    .mem_pause_i  (mem_pause),
    .mem_rdata_i  (mem_rdata),
    .mem_rvalid_i (mem_rvalid),
    .dbg_state_o  (dbg_state)
  );

  // Zero-latency memory model
  logic [31:0] fill_base = 32'd0;
  always_comb begin
    mem_rvalid = mem_rdreq & ~mem_pause;
    mem_rdata  = fill_base + ((mem_addr >> 2) & 32'h1f) * 32'd3;
  end

  // Pause generator: toggles every cycle while enabled
  logic pause_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_pause = pause_en ? ~mem_pause : 1'b0;
    end
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_wr_q[$];   // {addr, data} of each accepted memory write
  logic [31:0] exp_ra_q[$];   // address of each accepted memory read
  logic [31:0] exp_rd0_q[$];  // read port 0 data
  logic [31:0] exp_rd1_q[$];  // read port 1 data
  logic [31:0] model [NW];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", nm, act, $time);
  endtask

  // Monitor
  logic        prev_hold = 1'b0;
  logic [63:0] prev_aw   = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("mem_hold_stable", {mem_addr, mem_wdata}, prev_aw);
      prev_hold = (mem_wrreq | mem_rdreq) & mem_pause;
      prev_aw   = {mem_addr, mem_wdata};

      if (mem_wrreq && !mem_pause) begin
        if (exp_wr_q.size() == 0) unexpected("mem_wr", {mem_addr, mem_wdata});
        else chk("mem_wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
      end
      if (mem_rdreq && !mem_pause) begin
        if (exp_ra_q.size() == 0) unexpected("mem_rd_addr", {32'd0, mem_addr});
        else chk("mem_rd_addr", {32'd0, mem_addr}, {32'd0, exp_ra_q.pop_front()});
      end
      if (rd_valid[0]) begin
        if (exp_rd0_q.size() == 0) unexpected("rd0_data", {32'd0, rd_data[31:0]});
        else chk("rd0_data", {32'd0, rd_data[31:0]}, {32'd0, exp_rd0_q.pop_front()});
      end
      if (rd_valid[1]) begin
        if (exp_rd1_q.size() == 0) unexpected("rd1_data", {32'd0, rd_data[63:32]});
        else chk("rd1_data", {32'd0, rd_data[63:32]}, {32'd0, exp_rd1_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req    = '0;
    wr_req    = 1'b0;
    wr_be     = '0;
    ctl_fill  = 1'b0;
    ctl_flush = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (!line_ready && n < lim) begin
      step();
      n++;
    end
    chk("ready_within_budget", {63'd0, line_ready}, 64'd1);
  endtask

  task automatic push_fill_addrs(input logic [31:0] base, input int count);
    for (int k = 0; k < count; k++) exp_ra_q.push_back(base + 32'(k) * 32'd4);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},  {63'd0, line_ready}, 64'd1);
    chk({tag, "_valid"},  {63'd0, line_valid}, 64'd0);
    chk({tag, "_dirty"},  {63'd0, line_dirty}, 64'd0);
    chk({tag, "_region"}, {39'd0, line_region}, 64'd0);
    chk({tag, "_ttl"},    {56'd0, line_ttl}, 64'd255);
    chk({tag, "_rdv"},    {62'd0, rd_valid}, 64'd0);
    chk({tag, "_rdd"},    rd_data, 64'd0);
    chk({tag, "_memreq"}, {62'd0, mem_wrreq, mem_rdreq}, 64'd0);
    chk({tag, "_memaw"},  {mem_addr, mem_wdata}, 64'd0);
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    ctl_region = '0;
    ttl_tick   = 1'b0;

    // ---- reset ----
    repeat (3) step();
    reset_checks("rst_held");
    reset_n = 1'b1;
    step();
    reset_checks("rst_rel");

    // ---- fill region 0x12, memory returns 3*index ----
    fill_base = 32'd0;
    push_fill_addrs(32'h900, NW);
    ctl_fill = 1'b1; ctl_region = TG'(32'h12);
    step();
    idle();
    chk("fill_ready_low", {63'd0, line_ready}, 64'd0);
    chk("fill_first_req", {31'd0, mem_rdreq, mem_addr}, {31'd1, 32'h900});
    wait_ready(100);
    chk("fill_valid", {62'd0, line_valid, line_dirty}, 64'd2);
    chk("fill_region", {39'd0, line_region}, 64'h12);
    chk("fill_ttl", {56'd0, line_ttl}, 64'd255);
    chk("fill_all_reads", 64'(exp_ra_q.size()), 64'd0);
    for (int k = 0; k < NW; k++) model[k] = 32'(k) * 32'd3;

    // ---- read 0x908 on port 1 ----
    rd_addr = {32'h908, 32'h0};
    rd_req  = 2'b10;
    exp_rd1_q.push_back(32'd6);
    @(negedge clk);
    chk("rd908_miss", {62'd0, rd_miss}, 64'd0);
    step();
    idle();
    chk("rd908_valid", {62'd0, rd_valid}, 64'd2);

    // ---- byte-enabled write 0x904 ----
    wr_addr = 32'h904; wr_data = 32'hAABBCCDD; wr_be = 4'b0101; wr_req = 1'b1;
    @(negedge clk);
    chk("wr904_ack", {63'd0, wr_ack}, 64'd1);
    step();
    idle();
    chk("wr904_dirty", {63'd0, line_dirty}, 64'd1);
    model[1] = 32'h00BB00DD;

    // ---- hit/miss split: port0 0x920 hit, port1 0x1000 miss ----
    rd_addr = {32'h1000, 32'h920};
    rd_req  = 2'b11;
    exp_rd0_q.push_back(32'h18);
    @(negedge clk);
    chk("split_miss", {62'd0, rd_miss}, 64'd2);
    step();
    idle();
    chk("split_valid", {62'd0, rd_valid}, 64'd1);

    // ---- read-back of merged word plus read-before-write on 0x908 ----
    rd_addr = {32'h908, 32'h904};
    rd_req  = 2'b11;
    wr_addr = 32'h908; wr_data = 32'h11223344; wr_be = 4'hF; wr_req = 1'b1;
    exp_rd0_q.push_back(32'h00BB00DD);
    exp_rd1_q.push_back(32'd6);
    step();
    idle();
    chk("rbw_valid", {62'd0, rd_valid}, 64'd3);
    model[2] = 32'h11223344;
    rd_addr = {32'h908, 32'h0};
    rd_req  = 2'b10;
    exp_rd1_q.push_back(32'h11223344);
    step();
    idle();
    chk("after_wr_valid", {62'd0, rd_valid}, 64'd2);

    // ---- flush+fill region 0x13 with toggling pause ----
    for (int k = 0; k < NW; k++) exp_wr_q.push_back({32'h900 + 32'(k) * 32'd4, model[k]});
    push_fill_addrs(32'h980, NW);
    fill_base = 32'h1000;
    pause_en  = 1'b1;
    ctl_fill = 1'b1; ctl_flush = 1'b1; ctl_region = TG'(32'h13);
    step();
    idle();
    chk("ff_ready_low", {63'd0, line_ready}, 64'd0);
    chk("ff_first_wr", {31'd0, mem_wrreq, mem_addr}, {31'd1, 32'h900});
    wait_ready(400);
    pause_en = 1'b0;
    chk("ff_all_writes", 64'(exp_wr_q.size()), 64'd0);
    chk("ff_all_reads", 64'(exp_ra_q.size()), 64'd0);
    chk("ff_region", {39'd0, line_region}, 64'h13);
    chk("ff_valid_dirty", {62'd0, line_valid, line_dirty}, 64'd2);
    for (int k = 0; k < NW; k++) model[k] = 32'h1000 + 32'(k) * 32'd3;
    step();
    rd_addr = {32'h9FC, 32'h984};
    rd_req  = 2'b11;
    exp_rd0_q.push_back(32'h1003);
    exp_rd1_q.push_back(32'h105D);
    step();
    idle();
    chk("ff_read_valid", {62'd0, rd_valid}, 64'd3);

    // ---- be=0 write on a clean line: ack, stays clean ----
    wr_addr = 32'h990; wr_data = 32'hFFFFFFFF; wr_be = 4'b0000; wr_req = 1'b1;
    @(negedge clk);
    chk("be0_ack", {63'd0, wr_ack}, 64'd1);
    step();
    idle();
    chk("be0_clean", {63'd0, line_dirty}, 64'd0);
    rd_addr = {32'h0, 32'h990};
    rd_req  = 2'b01;
    exp_rd0_q.push_back(32'h100C);
    step();
    idle();

    // ---- flush on a clean line ----
    ctl_flush = 1'b1;
    step();
    idle();
    chk("cflush_valid", {63'd0, line_valid}, 64'd0);
    chk("cflush_ready", {63'd0, line_ready}, 64'd1);
    chk("cflush_nowr", {63'd0, mem_wrreq}, 64'd0);
    step();
    chk("cflush_ready2", {62'd0, line_ready, mem_wrreq}, 64'd2);
    rd_addr = {32'h0, 32'h984};
    rd_req  = 2'b01;
    @(negedge clk);
    chk("cflush_miss", {62'd0, rd_miss}, 64'd1);
    step();
    idle();
    chk("cflush_no_rdv", {62'd0, rd_valid}, 64'd0);

    // ---- TTL aging ----
    fill_base = 32'd0;
    push_fill_addrs(32'h900, NW);
    ctl_fill = 1'b1; ctl_region = TG'(32'h12);
    step();
    idle();
    wait_ready(100);
    ttl_tick = 1'b1;
    repeat (10) step();
    chk("ttl_245", {56'd0, line_ttl}, 64'd245);
    repeat (290) step();
    chk("ttl_sat0", {56'd0, line_ttl}, 64'd0);
    ttl_tick = 1'b0;
    rd_addr = {32'h0, 32'h900};
    rd_req  = 2'b01;
    exp_rd0_q.push_back(32'd0);
    step();
    idle();
    chk("ttl_reload", {56'd0, line_ttl}, 64'd255);

    // ---- async reset in mid-fill ----
    fill_base = 32'h2000;
    push_fill_addrs(32'hA00, 10);
    ctl_fill = 1'b1; ctl_region = TG'(32'h14);
    step();
    idle();
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    reset_checks("midfill");
    step();
    step();
    reset_n = 1'b1;
    step();
    push_fill_addrs(32'hA00, NW);
    ctl_fill = 1'b1; ctl_region = TG'(32'h14);
    step();
    idle();
    wait_ready(100);
    chk("refill_valid", {63'd0, line_valid}, 64'd1);
    chk("refill_region", {39'd0, line_region}, 64'h14);
    rd_addr = {32'hA28, 32'hA7C};
    rd_req  = 2'b11;
    exp_rd0_q.push_back(32'h205D);
    exp_rd1_q.push_back(32'h201E);
    step();
    idle();
    chk("refill_rdv", {62'd0, rd_valid}, 64'd3);
    step();
    step();

    // ---- drain ----
    chk("q_wr_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("q_ra_empty", 64'(exp_ra_q.size()), 64'd0);
    chk("q_rd0_empty", 64'(exp_rd0_q.size()), 64'd0);
    chk("q_rd1_empty", 64'(exp_rd1_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
